// File: rtl/twiddle_gen_if.sv
// Command and twiddle-output stream bundle for twiddle_gen.
interface twiddle_gen_if #(
    parameter int LOG2N = 3,
    parameter int WIDTH = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LOG2N-1:0]        cmd_base;
    logic [LOG2N-1:0]        cmd_stride;
    logic [LOG2N:0]          cmd_count;
    logic                    cmd_inv;
    logic                    tw_valid;
    logic                    tw_ready;
    logic signed [WIDTH-1:0] tw_re;
    logic signed [WIDTH-1:0] tw_im;
    logic                    tw_last;
    logic                    busy;

    // Host side: issues sweep commands and consumes twiddle words.
    modport master (
        output cmd_valid, cmd_base, cmd_stride, cmd_count, cmd_inv, tw_ready,
        input  cmd_ready, tw_valid, tw_re, tw_im, tw_last, busy
    );

    // Generator side.
    modport slave (
        input  cmd_valid, cmd_base, cmd_stride, cmd_count, cmd_inv, tw_ready,
        output cmd_ready, tw_valid, tw_re, tw_im, tw_last, busy
    );
endinterface

// File: rtl/twiddle_gen.sv
// Streaming FFT twiddle generator: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N)
// for an arithmetic sweep of k, built from a quarter-wave cosine table with
// symmetry folding. Optional conjugation for the inverse transform.
module twiddle_gen #(
    parameter int LOG2N = 3,
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    twiddle_gen_if.slave bus
);
    localparam int N      = 1 << LOG2N;
    localparam int ADDR_W = LOG2N - 1;
    localparam int TAB_SZ = 1 << ADDR_W;
    localparam int QTR    = N / 4;
    localparam int SCALE  = (1 << (WIDTH - 1)) - 1;

    localparam logic [ADDR_W-1:0]      QTR_A = ADDR_W'(QTR);
    localparam logic [LOG2N:0]         ONE   = (LOG2N + 1)'(1);
    localparam logic signed [WIDTH:0]  SMAX  = (WIDTH + 1)'(SCALE);
    localparam logic signed [WIDTH:0]  SMIN  = -SMAX;

    // Clamp an integer to symmetric full scale +/-S.
    function automatic logic signed [WIDTH-1:0] sat_val(input int v);
        int c;
        c = v;
        if (c > SCALE)  c = SCALE;
        if (c < -SCALE) c = -SCALE;
        return WIDTH'(c);
    endfunction

    // Round-half-away-from-zero of S*cos(2*pi*m/N); entries past N/4 are unused.
    function automatic logic signed [WIDTH-1:0] cos_entry(input int m);
        real ang;
        real v;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
        v   = real'(SCALE) * $cos(ang);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        if (m > QTR)  r = 0;
        if (m == 0)   r = SCALE;
        return sat_val(r);
    endfunction

    // Optional negation, saturated to +/-S so full scale never wraps.
    function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x,
                                                        input logic en);
        logic signed [WIDTH:0] t;
        t = {x[WIDTH-1], x};
        if (en)       t = -t;
        if (t > SMAX) t = SMAX;
        if (t < SMIN) t = SMIN;
        return t[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] cos_tab [TAB_SZ];

    for (genvar g = 0; g < TAB_SZ; g++) begin : g_tab
        localparam logic signed [WIDTH-1:0] CV = cos_entry(g);
        assign cos_tab[g] = CV;
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [LOG2N-1:0] k_r;
    logic [LOG2N-1:0] stride_r;
    logic [LOG2N:0]   rem_r;
    logic             inv_r;
    logic             cmd_ready_r;
    logic             busy_r;

    logic adv;
    logic issue;
    logic last_hs;

    logic                    vld_p1;
    logic                    last_p1;
    logic [ADDR_W-1:0]       addr_p1;
    logic                    swap_p1;
    logic                    neg_re_p1;
    logic                    neg_im_p1;
    logic                    vld_p2;
    logic                    last_p2;
    logic signed [WIDTH-1:0] re_p2;
    logic signed [WIDTH-1:0] im_p2;

    logic [ADDR_W-1:0]       h_k;
    logic                    upper_k;
    logic [ADDR_W-1:0]       addr_nxt;
    logic                    swap_nxt;
    logic signed [WIDTH-1:0] x_tab;
    logic signed [WIDTH-1:0] y_tab;
    logic signed [WIDTH-1:0] fold_re;
    logic signed [WIDTH-1:0] fold_im;

    // Whole pipeline, issue included, moves only when the output slot frees.
    assign adv     = !vld_p2 || bus.tw_ready;
    assign issue   = (state == RUN) && adv;
    assign last_hs = vld_p2 && bus.tw_ready && last_p2;

    // Sweep sequencer: command accept, index issue, drain back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            k_r         <= '0;
            rem_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        k_r         <= bus.cmd_base;
                        rem_r       <= bus.cmd_count;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= (bus.cmd_count == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        k_r   <= k_r + stride_r;
                        rem_r <= rem_r - ONE;
                        if (rem_r == ONE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // An empty pipeline here means a zero-length sweep.
                    if (last_hs || (!vld_p1 && !vld_p2)) begin
                        state       <= IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stride and direction are plain data latched with the command.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cmd_valid) begin
            stride_r <= bus.cmd_stride;
            inv_r    <= bus.cmd_inv;
        end
    end

    // Fold k into a quarter-wave address: h <= N/4 reads C[h] directly,
    // otherwise the roles of cos/sin swap around address h - N/4.
    always_comb begin
        h_k     = k_r[ADDR_W-1:0];
        upper_k = k_r[LOG2N-1];
        if (h_k > QTR_A) begin
            addr_nxt = h_k - QTR_A;
            swap_nxt = 1'b1;
        end else begin
            addr_nxt = h_k;
            swap_nxt = 1'b0;
        end
    end

    // ---- S1: table address and fold flags ----
    // S1 data registers; validity travels separately in the control block.
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_p1   <= addr_nxt;
            swap_p1   <= swap_nxt;
            neg_re_p1 <= swap_nxt ^ upper_k;
            neg_im_p1 <= ~(upper_k ^ inv_r);
        end
    end

    // ---- S2: table lookup, fold and sign ----
    // Table read and sign application for the word held in S1.
    always_comb begin
        x_tab   = cos_tab[addr_p1];
        y_tab   = cos_tab[QTR_A - addr_p1];
        fold_re = neg_sat(swap_p1 ? y_tab : x_tab, neg_re_p1);
        fold_im = neg_sat(swap_p1 ? x_tab : y_tab, neg_im_p1);
    end

    // Pipeline valid/last bits and the registered output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            re_p2   <= '0;
            im_p2   <= '0;
        end else if (adv) begin
            vld_p1  <= issue;
            last_p1 <= issue && (rem_r == ONE);
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
                re_p2 <= fold_re;
                im_p2 <= fold_im;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.tw_valid  = vld_p2;
    assign bus.tw_last   = last_p2;
    assign bus.tw_re     = re_p2;
    assign bus.tw_im     = im_p2;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: LOG2N=3 and LOG2N=4 instances, trig reference model.
`timescale 1ns/1ps
module tb_twiddle_gen;
    localparam int W = 16;
    localparam int S = 32767;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    twiddle_gen_if #(.LOG2N(3), .WIDTH(W)) if3 ();
    twiddle_gen_if #(.LOG2N(4), .WIDTH(W)) if4 ();

    twiddle_gen #(.LOG2N(3), .WIDTH(W)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    twiddle_gen #(.LOG2N(4), .WIDTH(W)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    int n_cmp = 0;
    int n_err = 0;

    int got_re[$];
    int got_im[$];
    bit got_last[$];
    int t_first, t_last, t_rdy, n_stall, n_busy, n_stab, n_lastflag;

    // Reference: direct trigonometry, rounded half away from zero.
    function automatic int rnd_half(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic void ref_tw(input int lg, input int k, input bit inv,
                                   output int re, output int im);
        real ang;
        int  n;
        n   = 1 << lg;
        ang = 2.0 * 3.14159265358979323846 * real'(k % n) / real'(n);
        re  = rnd_half(real'(S) * $cos(ang));
        im  = -rnd_half(real'(S) * $sin(ang));
        if (inv) im = -im;
    endfunction

    task automatic set_cmd(input bit sel, input bit v, input int base, input int stride,
                           input int count, input bit inv);
        if (sel) begin
            if4.cmd_valid = v; if4.cmd_base = 4'(base); if4.cmd_stride = 4'(stride);
            if4.cmd_count = 5'(count); if4.cmd_inv = inv;
        end else begin
            if3.cmd_valid = v; if3.cmd_base = 3'(base); if3.cmd_stride = 3'(stride);
            if3.cmd_count = 4'(count); if3.cmd_inv = inv;
        end
    endtask

    task automatic set_ready(input bit sel, input bit r);
        if (sel) if4.tw_ready = r;
        else     if3.tw_ready = r;
    endtask

    task automatic peek(input bit sel, output bit v, output bit l, output int re,
                        output int im, output bit cr, output bit bs);
        if (sel) begin
            v = if4.tw_valid; l = if4.tw_last; re = if4.tw_re; im = if4.tw_im;
            cr = if4.cmd_ready; bs = if4.busy;
        end else begin
            v = if3.tw_valid; l = if3.tw_last; re = if3.tw_re; im = if3.tw_im;
            cr = if3.cmd_ready; bs = if3.busy;
        end
    endtask

    // Issue one command and collect the accepted words plus timing (cycles after accept).
    task automatic sweep(input bit sel, input int base, input int stride, input int count,
                         input bit inv, input bit rnd);
        bit v, l, cr, bs, r, stalled, plast;
        int re, im, pre, pim;
        got_re.delete(); got_im.delete(); got_last.delete();
        t_first = -1; t_last = -1; t_rdy = -1;
        n_stall = 0; n_busy = 0; n_stab = 0; n_lastflag = 0;
        stalled = 0; pre = 0; pim = 0; plast = 0;
        @(negedge clk);
        set_ready(sel, 1'b1);
        set_cmd(sel, 1'b1, base, stride, count, inv);
        @(negedge clk);
        set_cmd(sel, 1'b0, 0, 0, 0, 1'b0);
        for (int cyc = 1; cyc < 400; cyc++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            set_ready(sel, r);
            peek(sel, v, l, re, im, cr, bs);
            if (cr) begin
                t_rdy = cyc;
                break;
            end
            if (bs) n_busy++;
            if (v) begin
                if (t_first < 0) t_first = cyc;
                if (stalled && (re != pre || im != pim || l != plast)) n_stab++;
                if (r) begin
                    got_re.push_back(re); got_im.push_back(im); got_last.push_back(l);
                    if (l) begin t_last = cyc; n_lastflag++; end
                    stalled = 0;
                end else begin
                    n_stall++; stalled = 1; pre = re; pim = im; plast = l;
                end
            end
            @(negedge clk);
        end
        set_ready(sel, 1'b1);
    endtask

    task automatic test_reset;
        bit v, l, cr, bs;
        int re, im;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            peek(s[0], v, l, re, im, cr, bs);
            n_cmp++;
            if ({cr, bs, v, l} !== 4'b1000 || re != 0 || im != 0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: ready/busy/valid/last=%b%b%b%b re=%0d im=%0d required 1000 0 0",
                         s, cr, bs, v, l, re, im);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fwd_sweep;
        int exp_re[8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
        int exp_im[8] = '{0, -23170, -32767, -23170, 0, 23170, 32767, 23170};
        int mre, mim;
        sweep(1'b0, 0, 1, 8, 1'b0, 1'b0);
        n_cmp++;
        if (got_re.size() != 8) begin
            n_err++; $display("FAIL fwd_count: got %0d words required 8", got_re.size());
        end
        for (int i = 0; i < 8 && i < got_re.size(); i++) begin
            ref_tw(3, i, 1'b0, mre, mim);
            n_cmp++;
            if (got_re[i] != exp_re[i] || got_im[i] != exp_im[i] || mre != exp_re[i] ||
                mim != exp_im[i] || got_last[i] != (i == 7)) begin
                n_err++;
                $display("FAIL fwd_word%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                         i, got_re[i], got_im[i], got_last[i], exp_re[i], exp_im[i], i == 7);
            end
        end
        n_cmp++;
        if (t_first != 3 || t_last != 10 || t_rdy != 11 || n_busy != 10) begin
            n_err++;
            $display("FAIL fwd_timing: first=%0d last=%0d ready=%0d busy=%0d required 3 10 11 10",
                     t_first, t_last, t_rdy, n_busy);
        end
    endtask

    task automatic test_inv_sweep;
        int mre, mim;
        sweep(1'b0, 0, 1, 8, 1'b1, 1'b0);
        n_cmp++;
        if (got_re.size() != 8 || n_lastflag != 1) begin
            n_err++; $display("FAIL inv_count: got %0d words %0d lasts required 8 1", got_re.size(), n_lastflag);
        end
        for (int i = 0; i < 8 && i < got_re.size(); i++) begin
            ref_tw(3, i, 1'b1, mre, mim);
            n_cmp++;
            if (got_re[i] != mre || got_im[i] != mim) begin
                n_err++;
                $display("FAIL inv_word%0d: got (%0d,%0d) required (%0d,%0d)", i, got_re[i], got_im[i], mre, mim);
            end
        end
        n_cmp++;
        if (got_re.size() < 2 || got_re[1] != 23170 || got_im[1] != 23170) begin
            n_err++; $display("FAIL inv_word2_literal: got size %0d required (23170,23170)", got_re.size());
        end
    endtask

    task automatic test_wrap;
        int exp_re[4] = '{0, 23170, -32767, 23170};
        int exp_im[4] = '{32767, -23170, 0, 23170};
        sweep(1'b0, 6, 3, 4, 1'b0, 1'b0);
        n_cmp++;
        if (got_re.size() != 4 || t_rdy != 7) begin
            n_err++; $display("FAIL wrap_count: got %0d words ready=%0d required 4 7", got_re.size(), t_rdy);
        end
        for (int i = 0; i < 4 && i < got_re.size(); i++) begin
            n_cmp++;
            if (got_re[i] != exp_re[i] || got_im[i] != exp_im[i] || got_last[i] != (i == 3)) begin
                n_err++;
                $display("FAIL wrap_word%0d: got (%0d,%0d,last=%0d) required (%0d,%0d)",
                         i, got_re[i], got_im[i], got_last[i], exp_re[i], exp_im[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int base, stride, mre, mim, bad;
        bit inv;
        for (int it = 0; it < 3; it++) begin
            base = $urandom_range(0, 15); stride = $urandom_range(0, 15); inv = 1'($urandom_range(0, 1));
            sweep(1'b1, base, stride, 16, inv, 1'b1);
            bad = 0;
            for (int i = 0; i < got_re.size(); i++) begin
                ref_tw(4, (base + i * stride) % 16, inv, mre, mim);
                if (got_re[i] != mre || got_im[i] != mim || got_last[i] != (i == 15)) begin
                    if (bad == 0)
                        $display("FAIL bp_word it%0d i%0d: got (%0d,%0d,last=%0d) required (%0d,%0d,last=%0d)",
                                 it, i, got_re[i], got_im[i], got_last[i], mre, mim, i == 15);
                    bad++;
                end
            end
            n_cmp++;
            if (bad != 0 || got_re.size() != 16) begin
                n_err++; $display("FAIL bp_stream it%0d: %0d bad of %0d words required 0 of 16", it, bad, got_re.size());
            end
            n_cmp++;
            if (n_stab != 0 || n_lastflag != 1) begin
                n_err++; $display("FAIL bp_stable it%0d: unstable=%0d lasts=%0d required 0 1", it, n_stab, n_lastflag);
            end
            n_cmp++;
            if (t_rdy != 19 + n_stall) begin
                n_err++; $display("FAIL bp_timing it%0d: ready at %0d required %0d", it, t_rdy, 19 + n_stall);
            end
        end
    endtask

    task automatic test_count_zero;
        sweep(1'b0, 3, 1, 0, 1'b0, 1'b0);
        n_cmp++;
        if (got_re.size() != 0 || t_first != -1 || t_rdy != 2 || n_busy != 1) begin
            n_err++;
            $display("FAIL count_zero: words=%0d first=%0d ready=%0d busy=%0d required 0 -1 2 1",
                     got_re.size(), t_first, t_rdy, n_busy);
        end
    endtask

    task automatic test_reset_mid;
        bit v, l, cr, bs;
        int re, im, nw;
        nw = 0;
        @(negedge clk);
        set_ready(1'b0, 1'b1);
        set_cmd(1'b0, 1'b1, 0, 1, 8, 1'b0);
        @(negedge clk);
        set_cmd(1'b0, 1'b0, 0, 0, 0, 1'b0);
        for (int cyc = 1; cyc < 30 && nw < 3; cyc++) begin
            peek(1'b0, v, l, re, im, cr, bs);
            if (v) nw++;
            if (nw < 3) @(negedge clk);
        end
        n_cmp++;
        if (nw != 3) begin
            n_err++; $display("FAIL rstmid_reach: saw %0d words required 3", nw);
        end
        rst = 1'b1;
        #1;
        peek(1'b0, v, l, re, im, cr, bs);
        n_cmp++;
        if ({cr, bs, v, l} !== 4'b1000 || re != 0 || im != 0) begin
            n_err++;
            $display("FAIL rstmid_async: ready/busy/valid/last=%b%b%b%b re=%0d im=%0d required 1000 0 0",
                     cr, bs, v, l, re, im);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        peek(1'b0, v, l, re, im, cr, bs);
        n_cmp++;
        if ({cr, bs, v} !== 3'b100) begin
            n_err++; $display("FAIL rstmid_idle: ready/busy/valid=%b%b%b required 100", cr, bs, v);
        end
        sweep(1'b0, 2, 1, 1, 1'b0, 1'b0);
        n_cmp++;
        if (got_re.size() != 1 || got_re[0] != 0 || got_im[0] != -32767 || got_last[0] != 1'b1 || t_rdy != 4) begin
            n_err++;
            $display("FAIL rstmid_resume: words=%0d ready=%0d required one (0,-32767) with last, ready 4",
                     got_re.size(), t_rdy);
        end
    endtask

    task automatic test_back_to_back;
        int base, stride, count, lg, mre, mim, bad;
        bit inv, sel;
        for (int it = 0; it < 8; it++) begin
            sel = it[0];
            lg = sel ? 4 : 3;
            base = $urandom_range(0, (1 << lg) - 1);
            stride = $urandom_range(0, (1 << lg) - 1);
            count = $urandom_range(0, 1 << lg);
            inv = 1'($urandom_range(0, 1));
            sweep(sel, base, stride, count, inv, 1'b1);
            bad = 0;
            for (int i = 0; i < got_re.size(); i++) begin
                ref_tw(lg, (base + i * stride) % (1 << lg), inv, mre, mim);
                if (got_re[i] != mre || got_im[i] != mim || got_last[i] != (i == count - 1)) bad++;
            end
            n_cmp++;
            if (bad != 0 || got_re.size() != count || n_stab != 0) begin
                n_err++;
                $display("FAIL b2b_stream it%0d lg%0d: bad=%0d words=%0d unstable=%0d required 0 %0d 0",
                         it, lg, bad, got_re.size(), n_stab, count);
            end
            n_cmp++;
            if (t_rdy != ((count == 0) ? 2 : count + 3 + n_stall)) begin
                n_err++;
                $display("FAIL b2b_timing it%0d: ready at %0d required %0d", it, t_rdy,
                         (count == 0) ? 2 : count + 3 + n_stall);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_cmd(1'b0, 1'b0, 0, 0, 0, 1'b0);
        set_cmd(1'b1, 1'b0, 0, 0, 0, 1'b0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        test_reset();
        test_fwd_sweep();
        test_inv_sweep();
        test_wrap();
        test_backpressure();
        test_count_zero();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised, streaming twiddle-factor generator for the FFT core. It produces W_N^k = cos(2πk/N) − j·sin(2πk/N) for any N = 2^LOG2N, using a quarter-wave cosine table and symmetry folding. It emits a programmed arithmetic sweep of k (base, stride, count) as a valid/ready stream with backpressure. It supports the inverse transform (conjugated factors) and saturates to symmetric full scale, so +1.0 never overflows WIDTH.

## Interface
Parameters:
- LOG2N, 3: log2 of the transform size; legal range 3..12.
- WIDTH, 16: signed output width; scale S = 2^(WIDTH-1) − 1.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Reset, asynchronous and active-high.
- cmd_valid  in  1  Command present.
- cmd_ready  out  1  High only in IDLE.
- cmd_base  in  LOG2N  First index k0.
- cmd_stride  in  LOG2N  Index increment per output.
- cmd_count  in  LOG2N+1  Number of outputs, 0..N.
- cmd_inv  in  1  1 = conjugate (inverse FFT); latched with the command.
- tw_valid  out  1  Output word valid.
- tw_ready  in  1  Consumer ready.
- tw_re  out  WIDTH  Real part, signed.
- tw_im  out  WIDTH  Imaginary part, signed.
- tw_last  out  1  Marks the final word of a sweep.
- busy  out  1  High whenever the block is not in IDLE.

## Operation
- Table: C[m] = round(S·cos(2πm/N)), m = 0..N/4 (N/4+1 entries). It is computed at elaboration, and C[0] = S exactly.
- Folding, for k mod N:
  - k in [0, N/4]: re = C[k], im = −C[N/4−k].
  - k in (N/4, N/2): re = −C[N/2−k], im = −C[k−N/4].
  - k in [N/2, N): take the value for k−N/2 and negate both parts.
- When cmd_inv = 1, im is negated after folding. The magnitude is never 2^(WIDTH-1), so negation cannot overflow.
- Index sequence: k_i = (k0 + i·stride) mod N for i = 0..count−1. The address counter wraps modulo N.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch base, stride, count and inv. Go to RUN, or to DRAIN if count = 0.
  - RUN: issue one index per advancing cycle and decrement the remaining count. After issuing the last index, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the tw_last word has been accepted, then go to IDLE.
- A count = 0 command is accepted, produces no output words, and returns to IDLE 1 cycle later.
- Pipeline stages:
  - S1 registers the table address, the fold flags (swap, negate-re, negate-im) and last.
  - S2 registers the folded and signed output together with tw_valid and tw_last.
- Advance rule: the whole pipeline, including issue, advances when !tw_valid || tw_ready. Otherwise every stage holds, and tw_re, tw_im and tw_last stay stable while tw_valid = 1.
- Commands are never queued: cmd_ready = 0 in RUN and DRAIN.

## Timing
- Reset values: cmd_ready = 1, busy = 0, tw_valid = 0, tw_last = 0, tw_re = 0, tw_im = 0. The FSM enters IDLE, and the counters and pipeline valid bits clear.
- Command accepted in cycle T:
  - k0 is issued in T+1.
  - The first tw_valid appears in T+3 (3-cycle latency).
- With tw_ready held high, the block sustains 1 word per cycle, and the last word appears in T+2+count.
- cmd_ready rises in the cycle after the tw_last handshake; busy falls in the same cycle.
- Backpressure: when tw_ready is low for n cycles, completion is delayed by exactly n cycles and no word is lost or duplicated.
- Reset mid-sweep aborts immediately: outputs return to their reset values asynchronously and the remainder of the sweep is discarded.
- tw_ready is ignored when tw_valid = 0.

## Test plan
- LOG2N=3, WIDTH=16, base 0, stride 1, count 8, fwd, ready high:
  - Expected stream: (32767,0), (23170,−23170), (0,−32767), (−23170,−23170), (−32767,0), (−23170,23170), (0,32767), (23170,23170).
  - tw_last on word 8; first valid at T+3; cmd_ready high at T+11.
- Same command with inv=1: every im is negated, e.g. word 2 = (23170,23170); re is unchanged.
- LOG2N=3, base 6, stride 3, count 4: k sequence 6, 1, 4, 7 (wrap) → (0,32767), (23170,−23170), (−32767,0), (23170,23170).
- Backpressure: LOG2N=4, count 16, tw_ready toggled randomly:
  - Output must match a reference model word-for-word.
  - Data must be stable while stalled.
  - Exactly one tw_last.
- count=0 command: no tw_valid. cmd_ready is low for 1 cycle then high; busy pulses for 1 cycle.
- Assert rst during the 3rd word of a count=8 sweep:
  - Outputs go to their reset values immediately.
  - After release, cmd_ready = 1.
  - A new sweep with base 2, count 1 yields (0,−32767) with tw_last.
